// File: rtl/gsps_pkg.sv
// Shared constants and helpers for the polyphase shaper: symbol levels,
// derived sizing formulas and the output round/saturate step.
package gsps_pkg;

    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    localparam int RND_SHIFT = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int tpp_of(input int ntaps, input int osr);
        return (ntaps + osr - 1) / osr;
    endfunction

    function automatic int accw_of(input int width, input int tpp);
        return width + 3 + clog2(tpp);
    endfunction

    function automatic int lat_of(input int tpp);
        return 2 + clog2(tpp);
    endfunction

    // Round half-up by 2^RND_SHIFT, then clamp symmetrically to +/-(2^(width-1)-1).
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int width,
                                                     output logic sat);
        logic signed [63:0] r;
        logic signed [63:0] lim;
        r   = (acc + 64'sd4) >>> RND_SHIFT;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        sat = 1'b0;
        if (r > lim) begin
            r   = lim;
            sat = 1'b1;
        end else if (r < -lim) begin
            r   = -lim;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_polyphase_shaper_adder_tree.sv
// Fully pipelined binary adder tree: one register stage per level, inputs
// zero-padded up to a power of two, valid travels alongside the data.
module pipe_adder_tree
    import gsps_pkg::*;
#(
    parameter int N = 24,
    parameter int W = 26
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data [N],
    output logic                out_valid,
    output logic signed [W-1:0] out_data
);

    localparam int L = clog2(N);
    localparam int P = 1 << L;

    generate
        if (L == 0) begin : g_passthru
            assign out_data  = in_data[0];
            assign out_valid = in_valid;
        end else begin : g_tree
            logic signed [W-1:0] leaf [P];
            logic signed [W-1:0] sum_reg [1:P-1];
            logic                valid_reg [1:L];

            for (genvar gi = 0; gi < P; gi++) begin : g_leaf
                if (gi < N) begin : g_used
                    assign leaf[gi] = in_data[gi];
                end else begin : g_pad
                    assign leaf[gi] = '0;
                end
            end

            // Heap layout: node gi sums nodes 2gi and 2gi+1; root is node 1.
            for (genvar gi = 1; gi < P; gi++) begin : g_node
                if (2 * gi >= P) begin : g_bottom
                    always_ff @(posedge sys_clk or posedge reset) begin
                        if (reset) sum_reg[gi] <= '0;
                        else       sum_reg[gi] <= leaf[2*gi-P] + leaf[2*gi+1-P];
                    end
                end else begin : g_inner
                    always_ff @(posedge sys_clk or posedge reset) begin
                        if (reset) sum_reg[gi] <= '0;
                        else       sum_reg[gi] <= sum_reg[2*gi] + sum_reg[2*gi+1];
                    end
                end
            end

            for (genvar gi = 1; gi <= L; gi++) begin : g_valid
                if (gi == 1) begin : g_first
                    always_ff @(posedge sys_clk or posedge reset) begin
                        if (reset) valid_reg[gi] <= 1'b0;
                        else       valid_reg[gi] <= in_valid;
                    end
                end else begin : g_rest
                    always_ff @(posedge sys_clk or posedge reset) begin
                        if (reset) valid_reg[gi] <= 1'b0;
                        else       valid_reg[gi] <= valid_reg[gi-1];
                    end
                end
            end

            assign out_data  = sum_reg[1];
            assign out_valid = valid_reg[L];
        end
    endgenerate

endmodule

// File: rtl/lut_polyphase_shaper.sv
// Multiplier-free polyphase interpolating FIR for 4-ASK symbols with a
// runtime-loadable coefficient bank and a pipelined adder tree.
module lut_polyphase_shaper
    import gsps_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int NTAPS = 93,
    parameter int OSR   = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      sam_clk_en,
    input  logic                      sym_clk_en,
    input  logic [1:0]                sym_in,
    input  logic                      coef_we,
    input  logic [clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [WIDTH-1:0]   coef_wdata,
    output logic signed [WIDTH-1:0]   y,
    output logic                      y_valid,
    output logic                      ovf
);

    localparam int TPP   = tpp_of(NTAPS, OSR);
    localparam int ACCW  = accw_of(WIDTH, TPP);
    localparam int AW    = clog2(NTAPS);
    localparam int PW    = clog2(OSR);
    localparam int NCOEF = TPP * OSR;
    localparam int NW    = clog2(NCOEF);

    logic signed [WIDTH-1:0] coef_reg [NTAPS];
    logic signed [WIDTH-1:0] coef_ext [NCOEF];
    logic [PW-1:0]           phase_reg;
    logic [1:0]              sym_reg [TPP];
    logic                    samp_v_reg;
    logic signed [ACCW-1:0]  term_reg [TPP];
    logic                    term_v_reg;
    logic signed [ACCW-1:0]  acc_sum;
    logic                    acc_valid;
    logic signed [WIDTH-1:0] rs_val;
    logic                    rs_sat;

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset)
                    coef_reg[gi] <= '0;
                else if (coef_we && coef_addr == AW'(gi))
                    coef_reg[gi] <= coef_wdata;
            end
        end

        // Tail of the polyphase grid beyond NTAPS reads as constant zero.
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef_ext
            if (gi < NTAPS) begin : g_real
                assign coef_ext[gi] = coef_reg[gi];
            end else begin : g_zero
                assign coef_ext[gi] = '0;
            end
        end

        for (genvar gi = 0; gi < TPP; gi++) begin : g_dline
            if (gi == 0) begin : g_head
                always_ff @(posedge sys_clk or posedge reset) begin
                    if (reset)                        sym_reg[gi] <= SYM_M3;
                    else if (sam_clk_en && sym_clk_en) sym_reg[gi] <= sym_in;
                end
            end else begin : g_body
                always_ff @(posedge sys_clk or posedge reset) begin
                    if (reset)                        sym_reg[gi] <= SYM_M3;
                    else if (sam_clk_en && sym_clk_en) sym_reg[gi] <= sym_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            phase_reg  <= '0;
            samp_v_reg <= 1'b0;
            term_v_reg <= 1'b0;
        end else begin
            if (sam_clk_en)
                phase_reg <= sym_clk_en ? '0 : phase_reg + PW'(1);
            samp_v_reg <= sam_clk_en;
            term_v_reg <= samp_v_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < TPP; gi++) begin : g_term
            logic [NW-1:0]          tap_idx;
            logic signed [ACCW-1:0] h1;
            logic signed [ACCW-1:0] h3;

            assign tap_idx = NW'(phase_reg) + NW'(gi * OSR);
            assign h1      = ACCW'(coef_ext[tap_idx]);
            assign h3      = h1 + (h1 <<< 1);

            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) begin
                    term_reg[gi] <= '0;
                end else begin
                    case (sym_reg[gi])
                        SYM_M3:  term_reg[gi] <= -h3;
                        SYM_M1:  term_reg[gi] <= -h1;
                        SYM_P1:  term_reg[gi] <= h1;
                        default: term_reg[gi] <= h3;
                    endcase
                end
            end
        end
    endgenerate

    pipe_adder_tree #(
        .N (TPP),
        .W (ACCW)
    ) u_tree (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .in_valid  (term_v_reg),
        .in_data   (term_reg),
        .out_valid (acc_valid),
        .out_data  (acc_sum)
    );

    always_comb begin
        rs_sat = 1'b0;
        rs_val = WIDTH'(round_sat(64'(acc_sum), WIDTH, rs_sat));
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            y_valid <= acc_valid;
            ovf     <= acc_valid & rs_sat;
            if (acc_valid)
                y <= rs_val;
        end
    end

endmodule

// File: tb/tb_lut_polyphase_shaper.sv
// Directed bench for lut_polyphase_shaper: reset, DC, single tap, phase wrap,
// latency/throughput, saturation and live coefficient writes.
module tb_lut_polyphase_shaper;

    localparam int FLUSH = 12;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        sam_clk_en;
    logic        sym_clk_en;
    logic [1:0]  sym_in;
    logic        coef_we;
    logic [6:0]  coef_addr;
    logic [17:0] coef_wdata;
    logic [17:0] y;
    logic        y_valid;
    logic        ovf;

    int n_cmp = 0;
    int n_mis = 0;

    logic        pat_sam    [512];
    logic        pat_sym_en [512];
    logic [1:0]  pat_sym    [512];
    logic [1:0]  sym_seq    [64];
    int          wr_idx = -1;
    logic [6:0]  wr_addr;
    logic [17:0] wr_data;
    logic [17:0] cap_y [$];
    logic        cap_ovf [$];
    logic        cap_v [$];

    lut_polyphase_shaper dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .sym_in     (sym_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .y          (y),
        .y_valid    (y_valid),
        .ovf        (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        sym_in     = 2'b00;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
    endtask

    task automatic write_coef(input logic [6:0] a, input logic [17:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic load_all(input logic [17:0] d);
        for (int n = 0; n < 93; n++) write_coef(7'(n), d);
        $display("load: all 93 coefficients = %0d", $signed(d));
    endtask

    task automatic fill_symbols(input int nsym);
        for (int j = 0; j < nsym * 4; j++) begin
            pat_sam[j]    = 1'b1;
            pat_sym_en[j] = (j % 4 == 0);
            pat_sym[j]    = sym_seq[j / 4];
        end
    endtask

    task automatic run_pattern(input int nsamp);
        cap_y.delete();
        cap_ovf.delete();
        cap_v.delete();
        for (int i = 0; i < nsamp + FLUSH; i++) begin
            if (i < nsamp) begin
                sam_clk_en = pat_sam[i];
                sym_clk_en = pat_sym_en[i];
                sym_in     = pat_sym[i];
                coef_we    = (i == wr_idx);
                coef_addr  = wr_addr;
                coef_wdata = wr_data;
            end else begin
                clear_inputs();
            end
            tick();
            cap_v.push_back(y_valid);
            if (y_valid) begin
                cap_y.push_back(y);
                cap_ovf.push_back(ovf);
            end
        end
        clear_inputs();
        $display("stream: %0d samples driven, %0d outputs captured", nsamp, cap_y.size());
    endtask

    task automatic test_reset();
        n_cmp++; if (y !== 18'd0)   begin n_mis++; $display("FAIL reset_y: got %0d want 0", $signed(y)); end
        n_cmp++; if (y_valid !== 0) begin n_mis++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        n_cmp++; if (ovf !== 0)     begin n_mis++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        reset = 1'b0;
        tick();
        for (int m = 0; m < 8; m++) sym_seq[m] = 2'b11;
        fill_symbols(8);
        run_pattern(32);
        n_cmp++; if (cap_y.size() != 32) begin n_mis++; $display("FAIL reset_count: got %0d want 32", cap_y.size()); end
        for (int j = 0; j < cap_y.size(); j++) begin
            n_cmp++;
            if (cap_y[j] !== 18'd0) begin n_mis++; $display("FAIL reset_zero[%0d]: got %0d want 0", j, $signed(cap_y[j])); end
        end
    endtask

    task automatic test_dc();
        int e;
        load_all(18'd1000);
        for (int m = 0; m < 30; m++) sym_seq[m] = 2'b11;
        fill_symbols(30);
        run_pattern(120);
        n_cmp++; if (cap_y.size() != 120) begin n_mis++; $display("FAIL dc_count: got %0d want 120", cap_y.size()); end
        for (int j = 96; j < 120; j++) begin
            e = (j % 4 == 0) ? 9000 : 8625;
            n_cmp++;
            if ($signed(cap_y[j]) !== e) begin n_mis++; $display("FAIL dc_y[%0d]: got %0d want %0d", j, $signed(cap_y[j]), e); end
            n_cmp++;
            if (cap_ovf[j] !== 1'b0) begin n_mis++; $display("FAIL dc_ovf[%0d]: got %b want 0", j, cap_ovf[j]); end
        end
    endtask

    task automatic test_live_write();
        int e;
        // Line is already full of +3 from the DC run, so every sample is steady.
        wr_idx  = 49;
        wr_addr = 7'd0;
        wr_data = 18'd0;
        fill_symbols(30);
        run_pattern(120);
        n_cmp++; if (cap_y.size() != 120) begin n_mis++; $display("FAIL live_count: got %0d want 120", cap_y.size()); end
        for (int j = 0; j < 120; j++) begin
            e = (j % 4 == 0 && j < 49) ? 9000 : 8625;
            n_cmp++;
            if ($signed(cap_y[j]) !== e) begin n_mis++; $display("FAIL live_y[%0d]: got %0d want %0d", j, $signed(cap_y[j]), e); end
        end
        wr_idx  = 10;
        wr_addr = 7'd100;
        wr_data = 18'd5000;
        run_pattern(120);
        wr_idx  = -1;
        for (int j = 0; j < 120; j++) begin
            n_cmp++;
            if ($signed(cap_y[j]) !== 8625) begin n_mis++; $display("FAIL oob_write_y[%0d]: got %0d want 8625", j, $signed(cap_y[j])); end
        end
    endtask

    task automatic test_single_tap();
        int e;
        int m;
        load_all(18'd0);
        write_coef(7'd5, 18'd800);
        for (int k = 0; k < 33; k++) sym_seq[k] = (k == 24) ? 2'b11 : 2'b00;
        fill_symbols(33);
        run_pattern(132);
        n_cmp++; if (cap_y.size() != 132) begin n_mis++; $display("FAIL tap_count: got %0d want 132", cap_y.size()); end
        for (int j = 4; j < 132; j++) begin
            m = j / 4;
            if (j % 4 == 1) e = (m == 25) ? 300 : -300;
            else            e = 0;
            n_cmp++;
            if ($signed(cap_y[j]) !== e) begin n_mis++; $display("FAIL tap_y[%0d]: got %0d want %0d", j, $signed(cap_y[j]), e); end
        end
    endtask

    task automatic test_phase_wrap();
        int exp_ph [16];
        int e;
        exp_ph = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 1, 2};
        load_all(18'd0);
        write_coef(7'd0, 18'd80);
        write_coef(7'd1, 18'd160);
        write_coef(7'd2, 18'd240);
        write_coef(7'd3, 18'd320);
        for (int j = 0; j < 16; j++) begin
            pat_sam[j]    = 1'b1;
            pat_sym_en[j] = (j == 0 || j == 9 || j == 13);
            pat_sym[j]    = 2'b10;
        end
        run_pattern(16);
        n_cmp++; if (cap_y.size() != 16) begin n_mis++; $display("FAIL wrap_count: got %0d want 16", cap_y.size()); end
        for (int j = 0; j < 16; j++) begin
            e = 10 * (exp_ph[j] + 1);
            n_cmp++;
            if ($signed(cap_y[j]) !== e) begin n_mis++; $display("FAIL wrap_y[%0d]: got %0d want %0d", j, $signed(cap_y[j]), e); end
        end
    endtask

    task automatic test_latency();
        logic [15:0] tail;
        logic        e;
        int          ones;
        tail = 16'b1011_0011_1000_1101;
        ones = 0;
        for (int j = 0; j < 40; j++) begin
            pat_sam[j]    = (j < 24) ? 1'b1 : tail[15 - (j - 24)];
            pat_sym_en[j] = (j < 24) && (j % 4 == 0);
            pat_sym[j]    = 2'b01;
            if (pat_sam[j]) ones++;
        end
        run_pattern(40);
        for (int i = 0; i < 40 + FLUSH; i++) begin
            e = (i >= 7 && i - 7 < 40) ? pat_sam[i - 7] : 1'b0;
            n_cmp++;
            if (cap_v[i] !== e) begin n_mis++; $display("FAIL latency_valid[%0d]: got %b want %b", i, cap_v[i], e); end
        end
        n_cmp++; if (cap_y.size() != ones) begin n_mis++; $display("FAIL latency_count: got %0d want %0d", cap_y.size(), ones); end
    endtask

    task automatic test_saturation();
        load_all(18'd131071);
        for (int m = 0; m < 30; m++) sym_seq[m] = 2'b11;
        fill_symbols(30);
        run_pattern(120);
        for (int j = 96; j < 120; j++) begin
            n_cmp++;
            if ($signed(cap_y[j]) !== 131071) begin n_mis++; $display("FAIL satp_y[%0d]: got %0d want 131071", j, $signed(cap_y[j])); end
            n_cmp++;
            if (cap_ovf[j] !== 1'b1) begin n_mis++; $display("FAIL satp_ovf[%0d]: got %b want 1", j, cap_ovf[j]); end
        end
        for (int m = 0; m < 30; m++) sym_seq[m] = 2'b00;
        fill_symbols(30);
        run_pattern(120);
        for (int j = 96; j < 120; j++) begin
            n_cmp++;
            if ($signed(cap_y[j]) !== -131071) begin n_mis++; $display("FAIL satn_y[%0d]: got %0d want -131071", j, $signed(cap_y[j])); end
            n_cmp++;
            if (cap_ovf[j] !== 1'b1) begin n_mis++; $display("FAIL satn_ovf[%0d]: got %b want 1", j, cap_ovf[j]); end
        end
    endtask

    task automatic test_reset_midstream();
        load_all(18'd1000);
        for (int i = 0; i < 20; i++) begin
            sam_clk_en = 1'b1;
            sym_clk_en = (i % 4 == 0);
            sym_in     = 2'b11;
            tick();
        end
        n_cmp++; if (y_valid !== 1'b1) begin n_mis++; $display("FAIL rstmid_active: got %b want 1", y_valid); end
        #3;
        clear_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (y !== 18'd0)      begin n_mis++; $display("FAIL rstmid_y: got %0d want 0", $signed(y)); end
        n_cmp++; if (y_valid !== 1'b0) begin n_mis++; $display("FAIL rstmid_y_valid: got %b want 0", y_valid); end
        n_cmp++; if (ovf !== 1'b0)     begin n_mis++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
        tick();
        reset = 1'b0;
        tick();
        for (int m = 0; m < 10; m++) sym_seq[m] = 2'(m % 4);
        fill_symbols(10);
        run_pattern(40);
        n_cmp++; if (cap_y.size() != 40) begin n_mis++; $display("FAIL rstmid_count: got %0d want 40", cap_y.size()); end
        for (int j = 0; j < cap_y.size(); j++) begin
            n_cmp++;
            if (cap_y[j] !== 18'd0 || cap_ovf[j] !== 1'b0) begin
                n_mis++;
                $display("FAIL rstmid_zero[%0d]: got y=%0d ovf=%b want y=0 ovf=0", j, $signed(cap_y[j]), cap_ovf[j]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        test_reset();
        test_dc();
        test_live_write();
        test_single_tap();
        test_phase_wrap();
        test_latency();
        test_saturation();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
